// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
//   FB_W/FB_H   : frame-buffer size in words (320x240, 2x2 down-scaled screen)
//   SCR_W/SCR_H : visible VGA screen size (640x480)
//   PIX_W       : pixel width, {B,G,R} 4 bits each
//   swap_state_e: front/back bank swap FSM states (used when BANK_SWAP_EN is defined)
package vram_pkg;

  localparam int unsigned FB_W  = 320;
  localparam int unsigned FB_H  = 240;
  localparam int unsigned SCR_W = 640;
  localparam int unsigned SCR_H = 480;
  localparam int unsigned PIX_W = 12;

  typedef enum logic [1:0] {
    SwIdle,
    SwPend,
    SwSwap
  } swap_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VGA timing block, the drawing engine, the arbiter and the VRAM.
//   slave  : arbiter view (consumes VGA/draw/RAM-read signals, drives pixel/ready/RAM port)
//   master : environment view (VGA timing, drawing engine and VRAM model)
// Signals:
//   vga_rd/vga_row/vga_col -> pixel read request, vga_pix <- pixel one cycle later
//   vsync                  -> vertical sync (bank swap timing)
//   wr_valid/wr_x/wr_y/wr_data -> draw write, wr_ready <- accept
//   swap_req -> bank swap request, swap_done <- swap applied pulse
//   ram_addr/ram_we/ram_wdata <- VRAM port, ram_rdata -> VRAM read data (1-cycle latency)
interface vram_arbiter_if #(
  parameter int unsigned AW = 17
);
  logic          vga_rd;
  logic [9:0]    vga_row;
  logic [9:0]    vga_col;
  logic [11:0]   vga_pix;
  logic          vsync;
  logic          wr_valid;
  logic          wr_ready;
  logic [8:0]    wr_x;
  logic [7:0]    wr_y;
  logic [11:0]   wr_data;
  logic          swap_req;
  logic          swap_done;
  logic [AW:0]   ram_addr;
  logic          ram_we;
  logic [11:0]   ram_wdata;
  logic [11:0]   ram_rdata;

  modport slave (
    input  vga_rd, vga_row, vga_col, vsync, wr_valid, wr_x, wr_y, wr_data, swap_req,
           ram_rdata,
    output vga_pix, wr_ready, swap_done, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vga_rd, vga_row, vga_col, vsync, wr_valid, wr_x, wr_y, wr_data, swap_req,
           ram_rdata,
    input  vga_pix, wr_ready, swap_done, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO for drawing writes awaiting a free VRAM slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (drops all entries)
//   push, wdata: enqueue an entry (ignored when full)
//   pop        : dequeue the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry (valid when !empty)
// DEPTH must be a power of two so the pointers wrap naturally.
module vram_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rptr_q];

  // Storage carries no reset; validity is tracked by the counter alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous VRAM between VGA scan-out reads and buffered drawing
// writes. In-range VGA reads always own the RAM; queued writes drain into any other cycle.
// Screen coordinates (640x480) map onto the 320x240 frame buffer at 2x2 scale.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vram_arbiter_if.slave (VGA read, draw write, swap, VRAM port)
// Configuration:
//   BANK_SWAP_EN defined  : double buffering; reads use the front bank, writes the back bank
//                           (ram_addr MSB); swap_req swaps banks on a vsync rising edge once
//                           all buffered writes have drained.
//   BANK_SWAP_EN undefined: single bank, ram_addr MSB=0, swap_req ignored, swap_done=0.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 17
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);

  localparam int unsigned EW = AW + PIX_W;

  logic [8:0]    rd_y, rd_x;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_grant, wr_in_range, wr_ready, push, pop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] fifo_head;
  logic          rd_bank, wr_bank, swap_block;
  logic [AW:0]   addr_d, addr_q;
  logic          rd_valid_q;

  // y*320 + x as (y<<8)+(y<<6)+x; legal coordinates never exceed AW bits.
  assign rd_y    = bus.vga_row[9:1];
  assign rd_x    = bus.vga_col[9:1];
  assign rd_addr = (AW'(rd_y) << 8) + (AW'(rd_y) << 6) + AW'(rd_x);
  assign wr_addr = (AW'(bus.wr_y) << 8) + (AW'(bus.wr_y) << 6) + AW'(bus.wr_x);

  assign rd_grant    = bus.vga_rd && (bus.vga_row < 10'(SCR_H)) && (bus.vga_col < 10'(SCR_W));
  assign wr_in_range = (bus.wr_x < 9'(FB_W)) && (bus.wr_y < 8'(FB_H));

  assign wr_ready     = ~fifo_full & ~swap_block;
  assign bus.wr_ready = wr_ready;
  // Off-screen writes are accepted but never enter the queue.
  assign push         = bus.wr_valid & wr_ready & wr_in_range;
  assign pop          = ~rd_grant & ~fifo_empty;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({wr_addr, bus.wr_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // RAM port: read beats write; an idle cycle keeps the previous address on the bus.
  always_comb begin
    addr_d     = addr_q;
    bus.ram_we = 1'b0;
    if (rd_grant) begin
      addr_d = {rd_bank, rd_addr};
    end else if (!fifo_empty) begin
      addr_d     = {wr_bank, fifo_head[EW-1:PIX_W]};
      bus.ram_we = 1'b1;
    end
  end

  assign bus.ram_addr  = addr_d;
  assign bus.ram_wdata = fifo_head[PIX_W-1:0];
  assign bus.vga_pix   = rd_valid_q ? bus.ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rd_valid_q <= rd_grant;
    end
  end

`ifdef BANK_SWAP_EN
  swap_state_e state_q, state_d;
  logic        front_q, front_d;
  logic        vsync_q, vsync_rise;

  assign vsync_rise = bus.vsync & ~vsync_q;
  assign rd_bank    = front_q;
  assign wr_bank    = ~front_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SwIdle;
      front_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      vsync_q <= bus.vsync;
    end
  end

  // New writes are held off until the swap lands so the back bank is complete when shown.
  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    swap_block    = 1'b0;
    bus.swap_done = 1'b0;
    unique case (state_q)
      SwIdle: begin
        if (bus.swap_req) begin
          state_d = SwPend;
        end
      end
      SwPend: begin
        swap_block = 1'b1;
        if (fifo_empty && vsync_rise) begin
          state_d = SwSwap;
          front_d = ~front_q;
        end
      end
      SwSwap: begin
        swap_block    = 1'b1;
        bus.swap_done = 1'b1;
        state_d       = SwIdle;
      end
      default: state_d = SwIdle;
    endcase
  end
`else
  logic unused_swap;

  assign rd_bank       = 1'b0;
  assign wr_bank       = 1'b0;
  assign swap_block    = 1'b0;
  assign bus.swap_done = 1'b0;
  assign unused_swap   = bus.swap_req ^ bus.vsync;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned AW         = 17;
`ifdef BANK_SWAP_EN
  localparam logic WR_BANK = 1'b1;
`else
  localparam logic WR_BANK = 1'b0;
`endif
  // Pixel seen when reading location 645 of bank 0 after the first test's write.
  localparam logic [11:0] ABC_RD = WR_BANK ? 12'h000 : 12'hABC;

  logic clk, rst_n;
  vram_arbiter_if #(.AW(AW)) bus ();

  vram_arbiter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // VRAM model: synchronous read, one cycle latency.
  bit   [11:0] ram    [262144];
  bit   [11:0] shadow [262144];
  logic [11:0] rdata;
  assign bus.ram_rdata = rdata;
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    rdata <= ram[bus.ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rd;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [31:0] addr;
    logic [11:0] pix;
  } vec_t;

  typedef struct {
    logic [17:0] addr;
    logic [11:0] data;
  } wr_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.vga_rd   = 1'b0;
    bus.vga_row  = '0;
    bus.vga_col  = '0;
    bus.vsync    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_x     = '0;
    bus.wr_y     = '0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] wa(input int x, input int y);
    return 32'({WR_BANK, 17'(y * 320 + x)});
  endfunction

  vec_t vecs [8];
  wr_t  q [$];

  initial begin
    vecs[0] = '{1'b1, 10'd4,   10'd10,  32'd645,   12'h000};
    vecs[1] = '{1'b1, 10'd479, 10'd639, 32'd76799, ABC_RD};
    vecs[2] = '{1'b1, 10'd480, 10'd0,   32'd76799, 12'h000};
    vecs[3] = '{1'b0, 10'd0,   10'd0,   32'd76799, 12'h000};
    vecs[4] = '{1'b1, 10'd0,   10'd640, 32'd76799, 12'h000};
    vecs[5] = '{1'b1, 10'd1,   10'd1,   32'd0,     12'h000};
    vecs[6] = '{1'b1, 10'd2,   10'd3,   32'd321,   12'h000};
    vecs[7] = '{1'b0, 10'd0,   10'd0,   32'd321,   12'h000};

    idle_in();
    rst_n = 1'b0;
    #3;
    chk("rst_ready", 32'(bus.wr_ready), 1);
    chk("rst_pix", 32'(bus.vga_pix), 0);
    chk("rst_swap_done", 32'(bus.swap_done), 0);
    chk("rst_we", 32'(bus.ram_we), 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // Single in-range write drains on the next cycle.
    bus.wr_valid = 1'b1; bus.wr_x = 9'd5; bus.wr_y = 8'd2; bus.wr_data = 12'hABC;
    @(negedge clk);
    chk("w1_ready", 32'(bus.wr_ready), 1);
    chk("w1_we_same", 32'(bus.ram_we), 0);
    nxt();
    idle_in();
    @(negedge clk);
    chk("w1_we", 32'(bus.ram_we), 1);
    chk("w1_addr", 32'(bus.ram_addr), wa(5, 2));
    chk("w1_data", 32'(bus.ram_wdata), 32'h0ABC);
    nxt();
    @(negedge clk);
    chk("w1_idle_we", 32'(bus.ram_we), 0);
    chk("w1_idle_hold", 32'(bus.ram_addr), wa(5, 2));
    nxt();

    // Off-screen write: accepted, never reaches the RAM.
    bus.wr_valid = 1'b1; bus.wr_x = 9'd320; bus.wr_y = 8'd0; bus.wr_data = 12'h555;
    @(negedge clk);
    chk("oor_ready", 32'(bus.wr_ready), 1);
    nxt();
    idle_in();
    @(negedge clk);
    chk("oor_we", 32'(bus.ram_we), 0);
    chk("oor_hold", 32'(bus.ram_addr), wa(5, 2));
    nxt();

    // Address mapping / range table.
    for (int i = 0; i < 8; i++) begin
      bus.vga_rd = vecs[i].rd; bus.vga_row = vecs[i].row; bus.vga_col = vecs[i].col;
      @(negedge clk);
      chk($sformatf("tbl%0d_addr", i), 32'(bus.ram_addr), vecs[i].addr);
      chk($sformatf("tbl%0d_we", i), 32'(bus.ram_we), 0);
      chk($sformatf("tbl%0d_pix", i), 32'(bus.vga_pix), 32'(vecs[i].pix));
      nxt();
    end
    idle_in();

    // Full scan line of reads while four writes queue behind them.
    for (int k = 0; k < 640; k++) begin
      bus.vga_rd = 1'b1; bus.vga_row = 10'd10; bus.vga_col = 10'(k);
      bus.wr_valid = (k < 4); bus.wr_x = 9'(k + 1); bus.wr_y = 8'd3;
      bus.wr_data = 12'(12'h100 + k);
      @(negedge clk);
      if (k == 0 || k == 3) chk("scan_ready_open", 32'(bus.wr_ready), 1);
      if (k == 4) chk("scan_ready_full", 32'(bus.wr_ready), 0);
      if (bus.ram_we !== 1'b0 || bus.ram_addr !== 18'(1600 + k / 2)) begin
        chk($sformatf("scan_rd%0d", k), 32'({bus.ram_we, bus.ram_addr}),
            32'(1600 + k / 2));
      end else begin
        n_cmp++;
      end
      nxt();
    end
    idle_in();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_we", j), 32'(bus.ram_we), 1);
      chk($sformatf("drain%0d_addr", j), 32'(bus.ram_addr), wa(j + 1, 3));
      chk($sformatf("drain%0d_data", j), 32'(bus.ram_wdata), 32'(12'h100 + j));
      nxt();
    end
    @(negedge clk);
    chk("drain_done_we", 32'(bus.ram_we), 0);
    chk("drain_done_ready", 32'(bus.wr_ready), 1);
    nxt();

    // Reset in the middle of a drain with entries still queued.
    for (int k = 0; k < 4; k++) begin
      bus.vga_rd = 1'b1; bus.vga_row = 10'd20; bus.vga_col = 10'(k);
      bus.wr_valid = 1'b1; bus.wr_x = 9'(50 + k); bus.wr_y = 8'd50;
      bus.wr_data = 12'(12'h200 + k);
      nxt();
    end
    idle_in();
    @(negedge clk);
    chk("mid_pop_we", 32'(bus.ram_we), 1);
    nxt();
    bus.vga_rd = 1'b1; bus.vga_row = 10'd4; bus.vga_col = 10'd10;
    nxt();
    bus.vga_rd = 1'b0;
    #1;
    chk("pre_rst_pix", 32'(bus.vga_pix), 32'(ABC_RD));
    chk("pre_rst_we", 32'(bus.ram_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.ram_we), 0);
    chk("mid_rst_pix", 32'(bus.vga_pix), 0);
    chk("mid_rst_ready", 32'(bus.wr_ready), 1);
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("post_rst_we", 32'(bus.ram_we), 0);
      chk("post_rst_addr", 32'(bus.ram_addr), 0);
      nxt();
    end

    // Randomized traffic against a queue-based model.
    begin
      logic [11:0] exp_pix, nxt_pix;
      logic [17:0] last, ea;
      logic [9:0]  r, c;
      logic [8:0]  x;
      logic [7:0]  y;
      logic        rd, wv, rdy, rd_ok, ewe;
      wr_t         ent;
      exp_pix = '0;
      last    = '0;
      for (int n = 0; n < 3000; n++) begin
        rd = ($urandom_range(0, 9) < 7);
        r  = 10'($urandom_range(0, 500));
        c  = 10'($urandom_range(0, 660));
        wv = 1'($urandom_range(0, 1));
        x  = 9'($urandom_range(0, 330));
        y  = 8'($urandom_range(0, 250));
        bus.vga_rd = rd; bus.vga_row = r; bus.vga_col = c;
        bus.wr_valid = wv; bus.wr_x = x; bus.wr_y = y; bus.wr_data = 12'($urandom);
        @(negedge clk);
        rdy   = (q.size() < FIFO_DEPTH);
        rd_ok = rd && (r < 480) && (c < 640);
        chk("rnd_pix", 32'(bus.vga_pix), 32'(exp_pix));
        chk("rnd_ready", 32'(bus.wr_ready), 32'(rdy));
        nxt_pix = '0;
        ewe     = 1'b0;
        if (rd_ok) begin
          ea      = {1'b0, 17'((r / 2) * 320 + c / 2)};
          nxt_pix = shadow[ea];
        end else if (q.size() > 0) begin
          ent = q.pop_front();
          ea  = ent.addr;
          ewe = 1'b1;
          chk("rnd_wdata", 32'(bus.ram_wdata), 32'(ent.data));
          shadow[ea] = ent.data;
        end else begin
          ea = last;
        end
        chk("rnd_we", 32'(bus.ram_we), 32'(ewe));
        chk("rnd_addr", 32'(bus.ram_addr), 32'(ea));
        last = ea;
        if (wv && rdy && x < 320 && y < 240) begin
          q.push_back('{{WR_BANK, 17'(y * 320 + x)}, bus.wr_data});
        end
        exp_pix = nxt_pix;
        nxt();
      end
    end

    do_reset();
    q.delete();

`ifdef BANK_SWAP_EN
    for (int i = 0; i < 2; i++) begin
      bus.vga_rd = 1'b1; bus.wr_valid = 1'b1; bus.wr_x = 9'(7 + i); bus.wr_y = 8'd1;
      bus.wr_data = (i == 0) ? 12'h111 : 12'h222;
      @(negedge clk);
      chk("swap_push_ready", 32'(bus.wr_ready), 1);
      nxt();
    end
    bus.wr_valid = 1'b0; bus.swap_req = 1'b1;
    nxt();
    bus.swap_req = 1'b0; bus.vga_rd = 1'b0;
    @(negedge clk);
    chk("swap_pend_ready", 32'(bus.wr_ready), 0);
    chk("swap_w0_addr", 32'(bus.ram_addr), (1 << 17) + 327);
    chk("swap_w0_data", 32'(bus.ram_wdata), 32'h111);
    nxt();
    @(negedge clk);
    chk("swap_w1_addr", 32'(bus.ram_addr), (1 << 17) + 328);
    nxt();
    @(negedge clk);
    chk("swap_wait_done", 32'(bus.swap_done), 0);
    chk("swap_wait_ready", 32'(bus.wr_ready), 0);
    nxt();
    bus.vsync = 1'b1;
    @(negedge clk);
    chk("swap_vs_done", 32'(bus.swap_done), 0);
    nxt();
    @(negedge clk);
    chk("swap_pulse", 32'(bus.swap_done), 1);
    nxt();
    bus.vga_rd = 1'b1; bus.vga_row = 10'd2; bus.vga_col = 10'd14;
    @(negedge clk);
    chk("swap_pulse_end", 32'(bus.swap_done), 0);
    chk("swap_ready_back", 32'(bus.wr_ready), 1);
    chk("swap_rd_bank1", 32'(bus.ram_addr), (1 << 17) + 327);
    nxt();
    bus.vga_rd = 1'b0;
    @(negedge clk);
    chk("swap_rd_pix", 32'(bus.vga_pix), 32'h111);
    nxt();
`else
    bus.swap_req = 1'b1;
    nxt();
    bus.swap_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.vsync = (i >= 1);
      @(negedge clk);
      chk("noswap_done", 32'(bus.swap_done), 0);
      chk("noswap_ready", 32'(bus.wr_ready), 1);
      nxt();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
